// File: rtl/narnet_closed_loop_seq.sv
// Seed / closed-loop prediction sequencer wrapped around a NARNet core.
// Optional feedback saturation is compiled in with `define NARSEQ_FB_CLAMP_EN.
module narnet_closed_loop_seq #(
    parameter int SEED_LEN  = 16,
    parameter int HORIZON   = 8,
    parameter int TIMEOUT   = 255,
    parameter int CLAMP_MAX = 96,
    parameter int CLAMP_MIN = -96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       nn_enable,
    output logic [7:0] nn_x,
    output logic       nn_x_ready,
    input  logic [7:0] nn_y,
    input  logic       nn_out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        SEED_ACC,
        SEED_ISS,
        SEED_WAIT,
        PRED_OUT,
        PRED_ISS,
        PRED_WAIT,
        ERR
    } state_t;

    localparam logic [7:0]  SEED_LAST = 8'(SEED_LEN - 1);
    localparam logic [7:0]  PRED_LAST = 8'(HORIZON - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

`ifdef NARSEQ_FB_CLAMP_EN
    localparam logic signed [7:0] FB_MAX = 8'(CLAMP_MAX);
    localparam logic signed [7:0] FB_MIN = 8'(CLAMP_MIN);

    function automatic logic [7:0] fb(input logic [7:0] x);
        if ($signed(x) > FB_MAX) begin
            return FB_MAX;
        end else if ($signed(x) < FB_MIN) begin
            return FB_MIN;
        end
        return x;
    endfunction
`else
    function automatic logic [7:0] fb(input logic [7:0] x);
        return x;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [7:0]  seed_cnt_q, seed_cnt_d;
    logic [7:0]  pred_cnt_q, pred_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  nn_x_q, nn_x_d;
    logic [7:0]  out_reg_q, out_reg_d;
    logic        timeout_err_q, timeout_err_d;
    logic        done_q, done_d;
    logic        nn_out_ready_q;
    logic        ev;
    logic        last_pred;

    // Only a rising edge of out_ready marks a finished core step.
    assign ev        = nn_out_ready & ~nn_out_ready_q;
    assign last_pred = (pred_cnt_q == PRED_LAST);

    // NOTE: every state element updates with non-blocking assignments so all
    // flops sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            seed_cnt_q     <= '0;
            pred_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            nn_x_q         <= '0;
            out_reg_q      <= '0;
            timeout_err_q  <= 1'b0;
            done_q         <= 1'b0;
            nn_out_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_cnt_q     <= seed_cnt_d;
            pred_cnt_q     <= pred_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            nn_x_q         <= nn_x_d;
            out_reg_q      <= out_reg_d;
            timeout_err_q  <= timeout_err_d;
            done_q         <= done_d;
            nn_out_ready_q <= nn_out_ready;
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        seed_cnt_d    = seed_cnt_q;
        pred_cnt_d    = pred_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        nn_x_d        = nn_x_q;
        out_reg_d     = out_reg_q;
        timeout_err_d = timeout_err_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = SEED_ACC;
                    seed_cnt_d    = '0;
                    pred_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                end
            end
            SEED_ACC: begin
                if (s_valid) begin
                    nn_x_d  = s_data;
                    state_d = SEED_ISS;
                end
            end
            SEED_ISS: begin
                tmo_cnt_d = '0;
                state_d   = SEED_WAIT;
            end
            SEED_WAIT: begin
                if (ev) begin
                    seed_cnt_d = seed_cnt_q + 8'd1;
                    if (seed_cnt_q == SEED_LAST) begin
                        out_reg_d = nn_y;
                        state_d   = PRED_OUT;
                    end else begin
                        state_d = SEED_ACC;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            PRED_OUT: begin
                if (m_ready) begin
                    pred_cnt_d = pred_cnt_q + 8'd1;
                    if (last_pred) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        nn_x_d  = fb(out_reg_q);
                        state_d = PRED_ISS;
                    end
                end
            end
            PRED_ISS: begin
                tmo_cnt_d = '0;
                state_d   = PRED_WAIT;
            end
            PRED_WAIT: begin
                if (ev) begin
                    out_reg_d = nn_y;
                    state_d   = PRED_OUT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE) && (state_q != ERR);
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign s_ready     = (state_q == SEED_ACC);
    assign m_valid     = (state_q == PRED_OUT);
    assign m_data      = out_reg_q;
    assign m_last      = (state_q == PRED_OUT) && last_pred;
    assign nn_enable   = 1'b1;
    assign nn_x        = nn_x_q;
    assign nn_x_ready  = (state_q == SEED_ISS) || (state_q == PRED_ISS);

endmodule

// File: tb/tb_narnet_closed_loop_seq.sv
// Self-checking bench for narnet_closed_loop_seq with a behavioural core model
// (y = x + 1, out_ready pulse six cycles after each x_ready pulse).
module tb_narnet_closed_loop_seq;

    localparam int SEED_LEN = 16;
    localparam int HORIZON  = 8;
    localparam int TIMEOUT  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       nn_enable;
    logic [7:0] nn_x;
    logic       nn_x_ready;
    logic [7:0] nn_y = 8'd0;
    logic       nn_out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    bit         model_mute = 1'b0;
    int         pend_dly   = 0;
    logic [7:0] exp_x_q[$];
    logic [7:0] exp_fb_q[$];
    logic [7:0] exp_y_q[$];

    narnet_closed_loop_seq #(
        .SEED_LEN (SEED_LEN),
        .HORIZON  (HORIZON),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .nn_enable    (nn_enable),
        .nn_x         (nn_x),
        .nn_x_ready   (nn_x_ready),
        .nn_y         (nn_y),
        .nn_out_ready (nn_out_ready)
    );

    always #5 clk = ~clk;

    // Core model: one outstanding request, reset together with the sequencer.
    always @(posedge clk) begin
        nn_out_ready <= 1'b0;
        if (!rst) begin
            pend_dly = 0;
        end else if (nn_x_ready && !model_mute) begin
            pend_dly = 6;
            nn_y <= 8'(nn_x + 8'd1);
        end else if (pend_dly != 0) begin
            pend_dly = pend_dly - 1;
            if (pend_dly == 0) nn_out_ready <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb_model(input logic [7:0] x);
`ifdef NARSEQ_FB_CLAMP_EN
        if ($signed(x) > 8'sd96)  return 8'd96;
        if ($signed(x) < -8'sd96) return 8'hA0;
`endif
        return x;
    endfunction

    // One run: seeds seed0, seed0+1, ...; optional stall, core mute or mid-run reset.
    task automatic run_seq(input string tag, input logic [7:0] seed0, input int stall_pred,
                           input int stall_len, input int mute_seed, input int rst_pred);
        int         seed_idx = 0;
        int         pred_hs = 0;
        int         seed_pulses = 0;
        int         stall_left = 0;
        int         stall_x = 0;
        int         stray_done = 0;
        int         tmo_cyc = -1;
        bit         stall_started = 1'b0;
        bit         poked = 1'b0;
        bit         done_due = 1'b0;
        bit         rst_arm = 1'b0;
        bit         rst_chk = 1'b0;
        bit         finished = 1'b0;
        bit         seen_m = 1'b0;
        logic [7:0] y;
        logic [7:0] fx;

        exp_x_q.delete();
        exp_fb_q.delete();
        exp_y_q.delete();
        y = 8'(seed0 + 8'(SEED_LEN));
        for (int p = 0; p < HORIZON; p++) begin
            exp_y_q.push_back(y);
            fx = fb_model(y);
            if (p < HORIZON - 1) exp_fb_q.push_back(fx);
            y = 8'(fx + 8'd1);
        end

        model_mute = 1'b0;
        m_ready    = 1'b1;
        s_valid    = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":busy_after_start"}, 32'(busy), 1);
        check({tag, ":tmo_err_cleared"}, 32'(timeout_err), 0);

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            start = 1'b0;
            if (tmo_cyc >= 0) tmo_cyc++;
            if (rst_chk) begin
                check({tag, ":rst_busy"}, 32'(busy), 0);
                check({tag, ":rst_m_valid"}, 32'(m_valid), 0);
                check({tag, ":rst_s_ready"}, 32'(s_ready), 0);
                check({tag, ":rst_done"}, 32'(done), 0);
                check({tag, ":rst_x_ready"}, 32'(nn_x_ready), 0);
                check({tag, ":rst_m_data"}, 32'(m_data), 0);
                check({tag, ":rst_nn_x"}, 32'(nn_x), 0);
                check({tag, ":rst_nn_enable"}, 32'(nn_enable), 1);
                rst      = 1'b1;
                finished = 1'b1;
            end else if (rst_arm) begin
                rst     = 1'b0;
                rst_arm = 1'b0;
                rst_chk = 1'b1;
            end else begin
                if (tmo_cyc == TIMEOUT) begin
                    check({tag, ":tmo_err_early"}, 32'(timeout_err), 0);
                    check({tag, ":tmo_busy_wait"}, 32'(busy), 1);
                end else if (tmo_cyc == TIMEOUT + 1) begin
                    check({tag, ":tmo_err_set"}, 32'(timeout_err), 1);
                    check({tag, ":tmo_busy_low"}, 32'(busy), 0);
                    check({tag, ":tmo_m_valid"}, 32'(m_valid), 0);
                end else if (tmo_cyc == TIMEOUT + 2) begin
                    check({tag, ":tmo_err_sticky"}, 32'(timeout_err), 1);
                    finished = 1'b1;
                end

                s_valid = (seed_idx < SEED_LEN);
                s_data  = 8'(seed0 + 8'(seed_idx));
                if (!poked && seed_idx == 8) begin
                    start = 1'b1;
                    poked = 1'b1;
                end

                if (done && !done_due) stray_done++;
                if (done_due) begin
                    check({tag, ":done_pulse"}, 32'(done), 1);
                    check({tag, ":done_busy"}, 32'(busy), 0);
                    finished = 1'b1;
                end

                if (s_ready && s_valid) begin
                    exp_x_q.push_back(s_data);
                    seed_idx++;
                end

                if (nn_x_ready) begin
                    if (stall_left > 0) stall_x++;
                    if (!seen_m) begin
                        seed_pulses++;
                        if (exp_x_q.size() == 0) check({tag, ":seed_x_extra"}, 32'(nn_x), 999);
                        else check({tag, ":seed_x"}, 32'(nn_x), 32'(exp_x_q.pop_front()));
                        if (mute_seed > 0 && seed_idx == mute_seed) begin
                            model_mute = 1'b1;
                            tmo_cyc    = 0;
                        end
                    end else begin
                        if (exp_fb_q.size() == 0) check({tag, ":fb_x_extra"}, 32'(nn_x), 999);
                        else check({tag, ":fb_x"}, 32'(nn_x), 32'(exp_fb_q.pop_front()));
                        if (rst_pred >= 0 && pred_hs == rst_pred) rst_arm = 1'b1;
                    end
                end

                if (m_valid) begin
                    seen_m = 1'b1;
                    if (pred_hs == stall_pred && !stall_started) begin
                        stall_started = 1'b1;
                        stall_left    = stall_len;
                    end
                    if (exp_y_q.size() == 0) check({tag, ":m_data_extra"}, 32'(m_data), 999);
                    else check({tag, ":m_data"}, 32'(m_data), 32'(exp_y_q[0]));
                    m_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                    if (m_ready) begin
                        check({tag, ":m_last"}, 32'(m_last), 32'(pred_hs == HORIZON - 1));
                        if (exp_y_q.size() > 0) exp_y_q.pop_front();
                        pred_hs++;
                        if (pred_hs == HORIZON) done_due = 1'b1;
                    end
                end else begin
                    m_ready = 1'b1;
                end
            end
            if (!finished) @(negedge clk);
        end

        if (!finished) check({tag, ":cycle_budget"}, 0, 1);
        check({tag, ":stray_done"}, 32'(stray_done), 0);
        check({tag, ":x_during_stall"}, 32'(stall_x), 0);
        if (mute_seed > 0) begin
            check({tag, ":seed_pulses_to_tmo"}, 32'(seed_pulses), 32'(mute_seed));
        end else if (rst_pred >= 0) begin
            check({tag, ":preds_before_rst"}, 32'(pred_hs), 32'(rst_pred));
        end else begin
            check({tag, ":seed_pulses"}, 32'(seed_pulses), SEED_LEN);
            check({tag, ":preds_left"}, 32'(exp_y_q.size()), 0);
            check({tag, ":fb_left"}, 32'(exp_fb_q.size()), 0);
        end

        s_valid    = 1'b0;
        m_ready    = 1'b1;
        start      = 1'b0;
        model_mute = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset:busy", 32'(busy), 0);
        check("reset:m_valid", 32'(m_valid), 0);
        check("reset:s_ready", 32'(s_ready), 0);
        check("reset:done", 32'(done), 0);
        check("reset:timeout_err", 32'(timeout_err), 0);
        check("reset:nn_enable", 32'(nn_enable), 1);
        check("reset:nn_x_ready", 32'(nn_x_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle:busy", 32'(busy), 0);

        run_seq("nominal", 8'd0, -1, 0, -1, -1);
        run_seq("backpressure", 8'd0, 2, 10, -1, -1);
        run_seq("timeout", 8'd0, -1, 0, 5, -1);
        run_seq("after_tmo", 8'd0, -1, 0, -1, -1);
        run_seq("midrun_rst", 8'd0, -1, 0, -1, 3);
        run_seq("rerun", 8'd0, -1, 0, -1, -1);
        run_seq("clamp_seeds", 8'd79, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/narnet_closed_loop_seq.md
Name: narnet_closed_loop_seq

Overview:
- Sequencer wrapped around the NARNet core; drives the core's x_in/x_ready/enable and consumes its y_out/out_ready.
- Seed phase: accepts SEED_LEN samples from an upstream stream and pushes them to the core one at a time. The core's one-step outputs are discarded, except the final one.
- Prediction phase: runs closed-loop. Each prediction goes downstream and is fed back as the next x_in, until HORIZON predictions have been emitted.
- Sits between the sample source / host FIFO and the result sink.

Parameters:
- SEED_LEN, 16, samples pushed before prediction starts (1..255); matches core feedbackDelay.
- HORIZON, 8, predictions emitted per run (1..255).
- TIMEOUT, 255, max cycles to wait for core out_ready per step (1..65535).
- CLAMP_MAX, 96, feedback clamp upper bound, S8.6 (+1.5); used only with the optional feature.
- CLAMP_MIN, -96, feedback clamp lower bound, S8.6 (-1.5); used only with the optional feature.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse after the last prediction handshake.
- timeout_err  out  1  sticky; set on core timeout, cleared by the next accepted start.
- s_valid  in  1  upstream seed sample valid.
- s_ready  out  1  seed sample accepted when s_valid & s_ready.
- s_data  in  8  seed sample, signed S8.6.
- m_valid  out  1  prediction valid.
- m_ready  in  1  downstream accepts.
- m_data  out  8  prediction, signed S8.6.
- m_last  out  1  high with the HORIZON-th prediction.
- nn_enable  out  1  core enable.
- nn_x  out  8  core x_in, signed.
- nn_x_ready  out  1  core x_ready, one-cycle pulse.
- nn_y  in  8  core y_out, signed.
- nn_out_ready  in  1  core out_ready.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; all outputs 0 except nn_enable=1; all counters 0; stored nn_out_ready=0.
- Reset mid-run abandons the run silently: no done, no m_valid. The core is reset separately by the system.
- Core completion event: ev = nn_out_ready & ~nn_out_ready_q (rising edge, registered previous value). Events arriving in non-WAIT states are ignored.

States:
- IDLE: start=1 -> SEED_ACC; seed_cnt=0, pred_cnt=0, timeout_err=0, busy=1. start while busy is ignored.
- SEED_ACC: s_ready=1. On handshake, latch s_data into nn_x -> SEED_ISS.
- SEED_ISS: nn_x_ready=1 for exactly this cycle -> SEED_WAIT; tmo_cnt=0.
- SEED_WAIT: wait for ev.
  - On ev: seed_cnt+1. If the new seed_cnt==SEED_LEN, latch nn_y into out_reg -> PRED_OUT; else -> SEED_ACC.
  - Timeout: tmo_cnt increments each cycle; reaching TIMEOUT -> ERR.
- PRED_OUT: m_valid=1, m_data=out_reg, m_last=(pred_cnt==HORIZON-1). m_data is held stable while m_valid & ~m_ready.
  - On m_ready: pred_cnt+1. If last -> IDLE, pulse done, busy=0. Else nn_x=fb(out_reg) -> PRED_ISS.
- PRED_ISS: nn_x_ready pulse -> PRED_WAIT; tmo_cnt=0.
- PRED_WAIT: on ev, out_reg=nn_y -> PRED_OUT. Timeout -> ERR.
- ERR: timeout_err=1, busy=0, m_valid=0 -> IDLE next cycle. No done pulse.

Rules and latencies:
- s_ready is 0 in every state except SEED_ACC.
- m_valid is 0 in every state except PRED_OUT.
- Backpressure on m_ready stalls the loop; no prediction is dropped or duplicated.
- Minimum latency from a seed handshake to nn_x_ready: 1 cycle.
- Minimum latency from ev to m_valid: 1 cycle.
- Feedback path fb(x)=x with the feature off; no arithmetic widening.

Optional Feature:
- Macro NARSEQ_FB_CLAMP_EN.
- Defined: fb(x) saturates to [CLAMP_MIN, CLAMP_MAX] via a signed compare before driving nn_x in prediction steps. Seed samples and m_data are never clamped.
- Undefined: fb(x)=x; CLAMP_* parameters are unused.

Test Plan:
Bench core model: on an x_ready pulse, returns y=x+1; out_ready is high for 1 cycle, 6 cycles later.
- Reset/idle: rst=0 for 3 cycles -> busy=0, m_valid=0, s_ready=0, done=0, timeout_err=0, nn_enable=1.
- Nominal run (SEED_LEN=16, HORIZON=8): start, then seeds 0..15 with s_valid held high, m_ready=1.
  - Exactly 16 nn_x_ready pulses in the seed phase, nn_x=0..15.
  - m_data=16,17,...,23; m_last only on 23; done pulse 1 cycle after the 23 handshake.
- Backpressure: m_ready=0 for 10 cycles at the 3rd prediction -> m_data holds 18, no nn_x_ready during the stall; the sequence resumes unchanged.
- Timeout (TIMEOUT=20): the model never raises out_ready after the 5th seed -> timeout_err=1 after 20 wait cycles, busy=0, no done. The next start clears timeout_err.
- Reset mid-run: rst=0 during PRED_WAIT of the 4th prediction -> all outputs return to reset values next cycle. A new start reruns correctly from seed 0.
- Clamp (NARSEQ_FB_CLAMP_EN, seeds ending at 94):
  - m_data = 95, 96, 97, ... while fed-back nn_x saturates at 96.
  - Without the macro, nn_x=95, 96, 97, ...
